// File: rtl/jrb8_pkg.sv
// rtl/jrb8_pkg.sv - shared states, opcodes and bus select codes for the jrb8 sequencer
package jrb8_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EX1    = 3'd3,
        S_EX2    = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ALU = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bus load selects (inflags)
    localparam logic [4:0] IN_OI   = 5'd0;
    localparam logic [4:0] IN_RAMI = 5'd1;
    localparam logic [4:0] IN_MARI = 5'd2;
    localparam logic [4:0] IN_AI   = 5'd3;
    localparam logic [4:0] IN_CI   = 5'd4;
    localparam logic [4:0] IN_DI   = 5'd5;
    localparam logic [4:0] IN_NONE = 5'd7;

    // Bus drive selects (outflags)
    localparam logic [3:0] OUT_IO   = 4'd0;
    localparam logic [3:0] OUT_AO   = 4'd1;
    localparam logic [3:0] OUT_CO   = 4'd2;
    localparam logic [3:0] OUT_DOO  = 4'd3;
    localparam logic [3:0] OUT_ROMO = 4'd4;
    localparam logic [3:0] OUT_RAMO = 4'd5;
    localparam logic [3:0] OUT_JMPO = 4'd6;
    localparam logic [3:0] OUT_NONE = 4'd7;

endpackage

// File: rtl/jrb8_wait_timer.sv
// rtl/jrb8_wait_timer.sv - per-step memory wait counter
// Ports: clk, reset (sync, active-high); clear restarts the count at step entry;
// count advances one waiting cycle; expired means the next waiting cycle is the
// WAIT_MAX-th, so the caller can leave the step on that very edge.
module jrb8_wait_timer
    import jrb8_pkg::*;
#(
    parameter int WAIT_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (count) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/jrb8_sequencer.sv
// rtl/jrb8_sequencer.sv - jrb8 instruction sequencer FSM
// Ports: clk, reset (sync, active-high), run, ir[7:0], mem_ready, zflag, cflag in;
// inflags[4:0], outflags[3:0], mem_req, ir_load, pc_inc, pc_load, halted, err out.
module jrb8_sequencer
    import jrb8_pkg::*;
#(
    parameter int WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic       mem_ready,
    input  logic       zflag,
    input  logic       cflag,
    output logic [4:0] inflags,
    output logic [3:0] outflags,
    output logic       mem_req,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       halted,
    output logic       err
);

    state_t     state_q, state_d;
    logic [3:0] opcode_q;
    logic       zf_q, cf_q;

    logic step_done;
    logic wait_inc;
    logic wait_expired;
    logic jump_taken;
    logic step_pc_inc;
    logic step_pc_load;
    logic has_ex2;

    // Operand bits of ir are consumed by the datapath, not the sequencer.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opcode_q <= OP_NOP;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= ir[7:4];
                zf_q     <= zflag;
                cf_q     <= cflag;
            end
        end
    end

    always_comb begin
        inflags      = IN_NONE;
        outflags     = OUT_NONE;
        mem_req      = 1'b0;
        halted       = 1'b0;
        err          = 1'b0;
        step_pc_inc  = 1'b0;
        step_pc_load = 1'b0;
        has_ex2      = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        state_d      = state_q;

        jump_taken = (opcode_q == OP_JMP) ||
                     ((opcode_q == OP_JZ) && zf_q) ||
                     ((opcode_q == OP_JC) && cf_q);

        // Bus selects come only from registered state/opcode/flags.
        case (state_q)
            S_FETCH: begin
                outflags = OUT_ROMO;
                mem_req  = 1'b1;
            end
            S_EX1: begin
                case (opcode_q)
                    OP_LDI: begin
                        outflags    = OUT_ROMO;
                        inflags     = IN_AI;
                        mem_req     = 1'b1;
                        step_pc_inc = 1'b1;
                    end
                    OP_LDA, OP_STA: begin
                        outflags    = OUT_ROMO;
                        inflags     = IN_MARI;
                        mem_req     = 1'b1;
                        step_pc_inc = 1'b1;
                        has_ex2     = 1'b1;
                    end
                    OP_ALU: begin
                        outflags = OUT_AO;
                        inflags  = IN_AI;
                    end
                    OP_OUT: begin
                        outflags = OUT_AO;
                        inflags  = IN_OI;
                    end
                    OP_JMP, OP_JZ, OP_JC: begin
                        if (jump_taken) begin
                            outflags     = OUT_ROMO;
                            mem_req      = 1'b1;
                            step_pc_load = 1'b1;
                        end else begin
                            // Skip the unused target byte.
                            step_pc_inc = 1'b1;
                        end
                    end
                    // NOP and unassigned opcodes spend an empty EX1 so every
                    // single-step instruction shares the same 3-cycle latency.
                    default: ;
                endcase
            end
            S_EX2: begin
                if (opcode_q == OP_LDA) begin
                    outflags = OUT_RAMO;
                    inflags  = IN_AI;
                    mem_req  = 1'b1;
                end else if (opcode_q == OP_STA) begin
                    outflags = OUT_AO;
                    inflags  = IN_RAMI;
                    mem_req  = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERROR: begin
                halted = 1'b1;
                err    = 1'b1;
            end
            default: ;
        endcase

        // A memory step completes only with mem_ready; all others in one cycle.
        step_done = !mem_req || mem_ready;
        wait_inc  = mem_req && !mem_ready;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (ir[7:4] == OP_HLT) ? S_HALT : S_EX1;
            end
            S_EX1: begin
                pc_inc  = step_pc_inc && step_done;
                pc_load = step_pc_load && step_done;
                if (step_done) begin
                    if (has_ex2) state_d = S_EX2;
                    else         state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_EX2: begin
                if (step_done) state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        if (wait_inc && wait_expired) state_d = S_ERROR;
    end

    jrb8_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (step_done),
        .count   (wait_inc),
        .expired (wait_expired)
    );

endmodule
